// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the round-robin AHB bus arbiter.
package ahb_arb_pkg;

    localparam int unsigned TENURE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GRANT    = 2'b01,
        ST_HANDOVER = 2'b10
    } arb_state_e;

    // Ceiling log2, used to validate that the hmaster width can index every master.
    function automatic int unsigned arb_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Request/grant bundle between the AHB masters and the bus arbiter.
interface ahb_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = 2
);
    logic [NUM_MASTERS-1:0] hreq;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic                   bus_busy;

    // Arbiter side.
    modport slave (
        input  hreq,
        input  hready,
        output hgrant,
        output hmaster,
        output bus_busy
    );

    // Fabric/master side.
    modport master (
        output hreq,
        output hready,
        input  hgrant,
        input  hmaster,
        input  bus_busy
    );
endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module ahb_rr_pick #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          last,
    output logic                   valid,
    output logic [MW-1:0]          idx
);

    always_comb begin : p_pick
        logic [MW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = MW'((32'(last) + k) % NUM_MASTERS);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with bounded tenure and a one-cycle handover gap.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = 2,
    parameter int unsigned MAX_TENURE  = 16
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_arbiter_if.slave   bus
);

    if (MW < arb_clog2(NUM_MASTERS) || NUM_MASTERS < 2 || NUM_MASTERS > 8 ||
        MAX_TENURE < 1 || MAX_TENURE > 255) begin : g_param_chk
        $error("ahb_arbiter: illegal parameter combination");
    end

    localparam logic [TENURE_W-1:0] TENURE_LOAD = TENURE_W'(MAX_TENURE - 1);

    arb_state_e             r_state,  w_state;
    logic [NUM_MASTERS-1:0] r_grant,  w_grant;
    logic [MW-1:0]          r_master, w_master;
    logic [MW-1:0]          r_last,   w_last;
    logic                   r_busy,   w_busy;
    logic [TENURE_W-1:0]    r_tenure, w_tenure;

    logic                   w_pick_valid;
    logic [MW-1:0]          w_pick_idx;
    logic                   w_others_req;

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_pick (
        .req   (bus.hreq),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Someone other than the current owner wants the bus.
    assign w_others_req = |(bus.hreq & ~r_grant);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_master <= '0;
            r_last   <= MW'(NUM_MASTERS - 1);
            r_busy   <= 1'b0;
            r_tenure <= '0;
        end else begin
            r_state  <= w_state;
            r_grant  <= w_grant;
            r_master <= w_master;
            r_last   <= w_last;
            r_busy   <= w_busy;
            r_tenure <= w_tenure;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_grant  = r_grant;
        w_master = r_master;
        w_last   = r_last;
        w_busy   = r_busy;
        w_tenure = r_tenure;

        unique case (r_state)
            ST_IDLE, ST_HANDOVER: begin
                if (w_pick_valid) begin
                    w_state  = ST_GRANT;
                    w_grant  = NUM_MASTERS'(1) << w_pick_idx;
                    w_master = w_pick_idx;
                    w_busy   = 1'b1;
                    w_tenure = TENURE_LOAD;
                end else begin
                    w_state = ST_IDLE;
                    w_grant = '0;
                    w_busy  = 1'b0;
                end
            end
            ST_GRANT: begin
                // Ownership only moves on completed transfers.
                if (bus.hready) begin
                    if (!bus.hreq[r_master] || (r_tenure == '0 && w_others_req)) begin
                        w_state = ST_HANDOVER;
                        w_grant = '0;
                        w_busy  = 1'b0;
                        w_last  = r_master;
                    end else if (r_tenure != '0) begin
                        w_tenure = r_tenure - TENURE_W'(1);
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_grant = '0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign bus.hgrant   = r_grant;
    assign bus.hmaster  = r_master;
    assign bus.bus_busy = r_busy;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: a request/owner model predicts each cycle's outputs.
module tb_ahb_arbiter;

    localparam int N  = 4;
    localparam int MW = 2;
    localparam int MT = 4;

    typedef struct packed {
        logic [N-1:0]  g;
        logic [MW-1:0] m;
        logic          b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ahb_arbiter_if #(.NUM_MASTERS(N), .MW(MW)) bus_if ();

    ahb_arbiter #(
        .NUM_MASTERS (N),
        .MW          (MW),
        .MAX_TENURE  (MT)
    ) dut (
        .hclk   (clk),
        .hreset (rst),
        .bus    (bus_if.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: who owns the bus and for how many completed transfers.
    int m_owner  = -1;
    int m_master = 0;
    int m_last   = N - 1;
    int m_held   = 0;

    bit rec_on = 1'b0;
    int seq_q[$];
    logic [N-1:0] prev_g = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] req, input logic rdy, input logic do_rst);
        if (do_rst) begin
            m_owner = -1; m_master = 0; m_last = N - 1; m_held = 0;
        end else if (m_owner >= 0) begin
            if (rdy) begin
                logic [N-1:0] others;
                others = req;
                others[m_owner] = 1'b0;
                if (!req[m_owner] || (m_held >= MT - 1 && others != '0)) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end
        end else begin
            int w;
            w = rr(req, m_last);
            if (w >= 0) begin
                m_owner = w; m_master = w; m_held = 0;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic rdy, input logic do_rst);
        exp_t e;
        @(negedge clk);
        #1;
        bus_if.hreq   = req;
        bus_if.hready = rdy;
        rst           = do_rst;
        model_step(req, rdy, do_rst);
        e.g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.m = MW'(m_master);
        e.b = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    // Asynchronous reset must clear the grant without waiting for an edge.
    task automatic mid_reset(input logic [N-1:0] req);
        step(req, 1'b1, 1'b1);
        #1;
        chk("async_rst_hgrant", int'(bus_if.hgrant), 0);
        chk("async_rst_busy", int'(bus_if.bus_busy), 0);
        chk("async_rst_hmaster", int'(bus_if.hmaster), 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hgrant", int'(bus_if.hgrant), int'(e.g));
            chk("hmaster", int'(bus_if.hmaster), int'(e.m));
            chk("bus_busy", int'(bus_if.bus_busy), int'(e.b));
            chk("onehot", int'($countones(bus_if.hgrant) <= 1), 1);
        end
        if (rec_on && bus_if.hgrant != '0 && bus_if.hgrant != prev_g)
            seq_q.push_back(int'(bus_if.hmaster));
        prev_g = bus_if.hgrant;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int own_cnt;
        logic [N-1:0] r;
        logic [N-1:0] rq;
        bus_if.hreq   = '0;
        bus_if.hready = 1'b1;
        #1;
        chk("reset_hgrant", int'(bus_if.hgrant), 0);
        chk("reset_busy", int'(bus_if.bus_busy), 0);

        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        // Single requester, then drop.
        repeat (3) step(4'b0001, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Two requesters taking turns, each dropping after three owned cycles.
        rec_on  = 1'b1;
        own_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            r = 4'b1010;
            if (m_owner >= 0 && own_cnt >= 3) r[m_owner] = 1'b0;
            step(r, 1'b1, 1'b0);
            own_cnt = (m_owner >= 0) ? own_cnt + 1 : 0;
        end
        rec_on = 1'b0;
        chk("rr_seq_len_ge3", int'(seq_q.size() >= 3), 1);
        if (seq_q.size() >= 3) begin
            chk("rr_order0", seq_q[0], 1);
            chk("rr_order1", seq_q[1], 3);
            chk("rr_order2", seq_q[2], 1);
        end
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Tenure preemption.
        step(4'b0001, 1'b1, 1'b0);
        repeat (10) step(4'b0101, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Stall freezes the owner and its tenure.
        repeat (2) step(4'b0001, 1'b1, 1'b0);
        repeat (5) step(4'b0101, 1'b0, 1'b0);
        repeat (8) step(4'b0101, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Lone owner keeps the bus past tenure expiry.
        repeat (20) step(4'b1000, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Reset while master 1 owns the bus, then restart priority from master 0.
        repeat (3) step(4'b0010, 1'b1, 1'b0);
        mid_reset(4'b0010);
        repeat (4) step(4'b0011, 1'b1, 1'b0);
        repeat (3) step(4'b0000, 1'b1, 1'b0);

        // Randomised traffic with stalls and occasional resets.
        rq = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) < 3) rq = N'($urandom);
            step(rq, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        step('0, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
